// File: rtl/corelet_seq.sv
// rtl/corelet_seq.sv - corelet job sequencer; CORELET_SEQ_PERF_EN adds perf_cyc/perf_stall counters
module corelet_seq #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int addr_w   = 11,
  parameter int len_w    = 8,
  parameter int prop_cyc = row + col
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [len_w-1:0]  cfg_n_act,
  input  logic [addr_w-1:0] cfg_w_base,
  input  logic [addr_w-1:0] cfg_x_base,
  input  logic [addr_w-1:0] cfg_p_base,
  input  logic              cfg_mode,
  input  logic              cfg_acc,
  input  logic              ofifo_valid,
  output logic [4:0]        inst,
  output logic              xmem_cen,
  output logic [addr_w-1:0] xmem_addr,
  output logic              ofifo_rd,
  output logic              sfu_en,
  output logic              pmem_ren,
  output logic [addr_w-1:0] pmem_raddr,
  output logic              pmem_wen,
  output logic [addr_w-1:0] pmem_waddr,
  output logic              busy,
  output logic              done
`ifdef CORELET_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cyc,
  output logic [15:0]       perf_stall
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_FILL, S_W_LOAD, S_W_PROP, S_X_FILL, S_EXEC, S_DRAIN, S_DONE
  } state_t;

  localparam logic [len_w-1:0] ONE_L  = len_w'(1);
  localparam logic [len_w-1:0] ROW_L  = len_w'(row);
  localparam logic [len_w-1:0] PROP_L = len_w'(prop_cyc);

  state_t             state_q, state_d;
  logic [len_w-1:0]   cnt_q, cnt_d;
  logic [len_w-1:0]   popped_q, popped_d;
  logic [len_w-1:0]   wr_cnt_q, wr_cnt_d;
  logic [2:0]         pipe_q;
  logic               l0_wr_q;
  logic [len_w-1:0]   n_act_q;
  logic [addr_w-1:0]  w_base_q, x_base_q, p_base_q;
  logic               mode_q, acc_q;

  logic accept, l0_rd, exec_b, wload, wr_pend;

  // State, counters, SRAM-latency-aligned l0_wr, pop pipeline and config latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      popped_q <= '0;
      wr_cnt_q <= '0;
      pipe_q   <= '0;
      l0_wr_q  <= 1'b0;
      n_act_q  <= '0;
      w_base_q <= '0;
      x_base_q <= '0;
      p_base_q <= '0;
      mode_q   <= 1'b0;
      acc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      popped_q <= popped_d;
      wr_cnt_q <= wr_cnt_d;
      l0_wr_q  <= ~xmem_cen;
      pipe_q   <= accept ? 3'b000 : {pipe_q[1:0], ofifo_rd};
      if (accept) begin
        n_act_q  <= cfg_n_act;
        w_base_q <= cfg_w_base;
        x_base_q <= cfg_x_base;
        p_base_q <= cfg_p_base;
        mode_q   <= cfg_mode;
        acc_q    <= cfg_acc;
      end
    end
  end

  // Next-state and all datapath controls
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    popped_d   = popped_q;
    wr_cnt_d   = wr_cnt_q;
    accept     = 1'b0;
    l0_rd      = 1'b0;
    exec_b     = 1'b0;
    wload      = 1'b0;
    xmem_cen   = 1'b1;
    xmem_addr  = '0;
    ofifo_rd   = 1'b0;
    sfu_en     = 1'b0;
    pmem_ren   = 1'b0;
    pmem_raddr = '0;
    pmem_wen   = 1'b0;
    pmem_waddr = '0;
    done       = 1'b0;
    // writes trail pops by one cycle, or by the SFU's three stages when accumulating
    wr_pend    = acc_q ? (|pipe_q) : pipe_q[0];
    busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_d  = S_W_FILL;
          cnt_d    = '0;
          popped_d = '0;
          wr_cnt_d = '0;
        end
      end
      S_W_FILL: begin
        // one extra cycle lets the last read land in L0
        if (cnt_q < ROW_L) begin
          xmem_cen  = 1'b0;
          xmem_addr = w_base_q + addr_w'(cnt_q);
          cnt_d     = cnt_q + ONE_L;
        end else begin
          state_d = S_W_LOAD;
          cnt_d   = '0;
        end
      end
      S_W_LOAD: begin
        l0_rd = 1'b1;
        wload = 1'b1;
        if (cnt_q == ROW_L - ONE_L) begin
          state_d = S_W_PROP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      S_W_PROP: begin
        if (cnt_q == PROP_L - ONE_L) begin
          state_d = (n_act_q == '0) ? S_DONE : S_X_FILL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      S_X_FILL: begin
        if (cnt_q < n_act_q) begin
          xmem_cen  = 1'b0;
          xmem_addr = x_base_q + addr_w'(cnt_q);
          cnt_d     = cnt_q + ONE_L;
        end else begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        l0_rd  = 1'b1;
        exec_b = 1'b1;
        if (cnt_q == n_act_q - ONE_L) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_L;
        end
      end
      S_DRAIN: begin
        sfu_en   = acc_q;
        ofifo_rd = ofifo_valid && (popped_q < n_act_q);
        if (ofifo_rd) begin
          popped_d = popped_q + ONE_L;
          if (acc_q) begin
            pmem_ren   = 1'b1;
            pmem_raddr = p_base_q + addr_w'(popped_q);
          end
        end
        pmem_wen = acc_q ? pipe_q[2] : pipe_q[0];
        if (pmem_wen) begin
          pmem_waddr = p_base_q + addr_w'(wr_cnt_q);
          wr_cnt_d   = wr_cnt_q + ONE_L;
        end
        if ((popped_q == n_act_q) && !wr_pend) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    inst = {l0_rd, l0_wr_q, busy & mode_q, exec_b, wload};
  end

`ifdef CORELET_SEQ_PERF_EN
  logic [31:0] perf_cyc_q;
  logic [15:0] perf_stall_q;

  // Job cycle count and drain starvation count; both hold after done
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      perf_cyc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy && (state_q != S_DONE)) perf_cyc_q <= perf_cyc_q + 32'd1;
      if ((state_q == S_DRAIN) && !ofifo_valid && (popped_q < n_act_q))
        perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_cyc   = perf_cyc_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_corelet_seq.sv
// tb/tb_corelet_seq.sv - directed self-checking bench for corelet_seq
module tb_corelet_seq;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  cfg_n_act;
  logic [10:0] cfg_w_base, cfg_x_base, cfg_p_base;
  logic        cfg_mode, cfg_acc, ofifo_valid;
  logic [4:0]  inst;
  logic        xmem_cen, ofifo_rd, sfu_en, pmem_ren, pmem_wen, busy, done;
  logic [10:0] xmem_addr, pmem_raddr, pmem_waddr;
`ifdef CORELET_SEQ_PERF_EN
  logic [31:0] perf_cyc;
  logic [15:0] perf_stall;
`endif

  corelet_seq dut (
    .clk(clk), .reset(reset), .start(start), .cfg_n_act(cfg_n_act),
    .cfg_w_base(cfg_w_base), .cfg_x_base(cfg_x_base), .cfg_p_base(cfg_p_base),
    .cfg_mode(cfg_mode), .cfg_acc(cfg_acc), .ofifo_valid(ofifo_valid),
    .inst(inst), .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .ofifo_rd(ofifo_rd),
    .sfu_en(sfu_en), .pmem_ren(pmem_ren), .pmem_raddr(pmem_raddr),
    .pmem_wen(pmem_wen), .pmem_waddr(pmem_waddr), .busy(busy), .done(done)
`ifdef CORELET_SEQ_PERF_EN
    , .perf_cyc(perf_cyc), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  logic mode_exp = 1'b0;

  int n_wl, n_ex, n_l0wr, n_done, n_pop, n_pop_inv, n_sfu, n_mode_err;
  int sfu_first, sfu_last, ex_last, done_cyc;
  logic [10:0] xaddr_q[$], waddr_q[$], ren_a[$];
  int wen_c[$], ren_c[$];

  always @(negedge clk) begin
    if (inst[0]) n_wl++;
    if (inst[1]) begin n_ex++; ex_last = cyc; end
    if (inst[3]) n_l0wr++;
    if (!xmem_cen) xaddr_q.push_back(xmem_addr);
    if (pmem_wen) begin waddr_q.push_back(pmem_waddr); wen_c.push_back(cyc); end
    if (pmem_ren) begin ren_a.push_back(pmem_raddr); ren_c.push_back(cyc); end
    if (ofifo_rd) begin n_pop++; if (!ofifo_valid) n_pop_inv++; end
    if (sfu_en) begin n_sfu++; if (sfu_first < 0) sfu_first = cyc; sfu_last = cyc; end
    if (done) begin n_done++; done_cyc = cyc; end
    if (busy ? (inst[2] !== mode_exp) : (inst[2] !== 1'b0)) n_mode_err++;
  end

  task automatic clear_logs();
    n_wl = 0; n_ex = 0; n_l0wr = 0; n_done = 0; n_pop = 0; n_pop_inv = 0;
    n_sfu = 0; n_mode_err = 0; sfu_first = -1; sfu_last = -1; ex_last = -1; done_cyc = -1;
    xaddr_q.delete(); waddr_q.delete(); ren_a.delete(); wen_c.delete(); ren_c.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [7:0] n, input logic [10:0] w, input logic [10:0] x,
                           input logic [10:0] p, input logic m, input logic a);
    @(posedge clk); #1;
    mode_exp = m;
    cfg_n_act = n; cfg_w_base = w; cfg_x_base = x; cfg_p_base = p; cfg_mode = m; cfg_acc = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // scramble config after acceptance; the latched copy must be used
    cfg_n_act = 8'h5A; cfg_w_base = 11'h3C3; cfg_x_base = 11'h2A5; cfg_p_base = 11'h155;
    cfg_mode = ~m; cfg_acc = ~a;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_exec(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (inst[1]) begin ok = 1'b1; break; end
    end
  endtask

  function automatic logic [31:0] qa(input logic [10:0] q[$], input int i);
    return (i < q.size()) ? {21'd0, q[i]} : 32'hDEAD_BEEF;
  endfunction

  bit ok;
  bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    reset = 1'b1; start = 1'b0; cfg_n_act = '0; cfg_w_base = '0; cfg_x_base = '0;
    cfg_p_base = '0; cfg_mode = 1'b0; cfg_acc = 1'b0; ofifo_valid = 1'b1;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst", {27'd0, inst}, 32'd0);
    check("rst_cen", {31'd0, xmem_cen}, 32'd1);
    check("rst_xaddr", {21'd0, xmem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ofifo_rd", {31'd0, ofifo_rd}, 32'd0);
    check("rst_pmem", {28'd0, sfu_en, pmem_ren, pmem_wen, 1'b0}, 32'd0);
    check("rst_paddr", {10'd0, pmem_raddr, pmem_waddr}, 32'd0);
    reset = 1'b0;

    // reset mid-EXEC
    start_job(8'd4, 11'h000, 11'h040, 11'h100, 1'b1, 1'b0);
    wait_exec(200, ok);
    check("midexec_reached", {31'd0, ok}, 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_inst", {27'd0, inst}, 32'd0);
    check("midrst_cen", {31'd0, xmem_cen}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // non-acc job after the reset
    clear_logs();
    start_job(8'd4, 11'h000, 11'h040, 11'h100, 1'b1, 1'b0);
    wait_done(300, ok);
    check("j1_done_seen", {31'd0, ok}, 32'd1);
    repeat (6) @(negedge clk);
    check("j1_xaddr_n", xaddr_q.size(), 32'd12);
    for (int i = 0; i < 8; i++) check("j1_xaddr_w", qa(xaddr_q, i), i);
    for (int i = 0; i < 4; i++) check("j1_xaddr_x", qa(xaddr_q, 8 + i), 32'h40 + i);
    check("j1_wl", n_wl, 32'd8);
    check("j1_exec", n_ex, 32'd4);
    check("j1_l0wr", n_l0wr, 32'd12);
    check("j1_wr_n", waddr_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) check("j1_waddr", qa(waddr_q, i), 32'h100 + i);
    check("j1_done_n", n_done, 32'd1);
    check("j1_ren_n", ren_a.size(), 32'd0);
    check("j1_sfu_n", n_sfu, 32'd0);
    check("j1_mode", n_mode_err, 32'd0);

    // acc job
    clear_logs();
    start_job(8'd3, 11'h010, 11'h050, 11'h020, 1'b0, 1'b1);
    wait_done(300, ok);
    check("j2_done_seen", {31'd0, ok}, 32'd1);
    repeat (6) @(negedge clk);
    check("j2_ren_n", ren_a.size(), 32'd3);
    check("j2_wen_n", waddr_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("j2_raddr", qa(ren_a, i), 32'h20 + i);
      check("j2_waddr", qa(waddr_q, i), 32'h20 + i);
      if (i < ren_c.size() && i < wen_c.size())
        check("j2_wr_lag", wen_c[i] - ren_c[i], 32'd3);
    end
    check("j2_sfu_first", sfu_first, ex_last + 1);
    check("j2_sfu_last", sfu_last, done_cyc - 1);
    check("j2_sfu_contig", n_sfu, sfu_last - sfu_first + 1);
    check("j2_done_n", n_done, 32'd1);
    check("j2_mode", n_mode_err, 32'd0);

    // ofifo_valid stalls mid-drain, write addresses wrap
    clear_logs();
    ofifo_valid = 1'b0;
    start_job(8'd4, 11'h000, 11'h040, 11'h7FE, 1'b0, 1'b0);
    wait_exec(200, ok);
    check("j3_exec_seen", {31'd0, ok}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!inst[1]) break;
    end
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 ofifo_valid = pat[i];
    end
    @(posedge clk); #1 ofifo_valid = 1'b1;
    wait_done(100, ok);
    check("j3_done_seen", {31'd0, ok}, 32'd1);
    repeat (6) @(negedge clk);
    check("j3_pops", n_pop, 32'd4);
    check("j3_pop_inv", n_pop_inv, 32'd0);
    check("j3_wr_n", waddr_q.size(), 32'd4);
    check("j3_waddr0", qa(waddr_q, 0), 32'h7FE);
    check("j3_waddr1", qa(waddr_q, 1), 32'h7FF);
    check("j3_waddr2", qa(waddr_q, 2), 32'h000);
    check("j3_waddr3", qa(waddr_q, 3), 32'h001);
    check("j3_done_n", n_done, 32'd1);

    // n_act = 0, weight addresses wrap
    clear_logs();
    start_job(8'd0, 11'h7FC, 11'h040, 11'h100, 1'b1, 1'b0);
    wait_done(200, ok);
    check("j4_done_seen", {31'd0, ok}, 32'd1);
    repeat (6) @(negedge clk);
    check("j4_exec", n_ex, 32'd0);
    check("j4_wen", waddr_q.size(), 32'd0);
    check("j4_wl", n_wl, 32'd8);
    check("j4_l0wr", n_l0wr, 32'd8);
    check("j4_xaddr_n", xaddr_q.size(), 32'd8);
    check("j4_xaddr3", qa(xaddr_q, 3), 32'h7FF);
    check("j4_xaddr4", qa(xaddr_q, 4), 32'h000);
    check("j4_done_n", n_done, 32'd1);

    // start held high through done
    clear_logs();
    @(posedge clk); #1;
    mode_exp = 1'b0;
    cfg_n_act = 8'd1; cfg_w_base = 11'h0; cfg_x_base = 11'h40; cfg_p_base = 11'h200;
    cfg_mode = 1'b0; cfg_acc = 1'b0;
    start = 1'b1;
    wait_done(300, ok);
    check("j5_done_seen", {31'd0, ok}, 32'd1);
    check("j5_busy_at_done", {31'd0, busy}, 32'd1);
    check("j5_one_job_wl", n_wl, 32'd8);
    @(negedge clk);
    check("j5_idle_busy", {31'd0, busy}, 32'd0);
    check("j5_idle_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("j5_restart_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 start = 1'b0;
    wait_done(300, ok);
    check("j5_done2_seen", {31'd0, ok}, 32'd1);
    repeat (6) @(negedge clk);
    check("j5_done_n", n_done, 32'd2);
    check("j5_wl_total", n_wl, 32'd16);

    // longest job
    clear_logs();
    start_job(8'd255, 11'h000, 11'h100, 11'h300, 1'b1, 1'b1);
    wait_done(2000, ok);
    check("j6_done_seen", {31'd0, ok}, 32'd1);
    repeat (6) @(negedge clk);
    check("j6_exec", n_ex, 32'd255);
    check("j6_wen", waddr_q.size(), 32'd255);
    check("j6_wlast", qa(waddr_q, 254), 32'h3FE);
    check("j6_mode", n_mode_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/corelet_seq.md
Name: corelet_seq

Overview:
- Job-level sequencer for the corelet datapath (L0 input FIFO, MAC array, OFIFO, SFU bank).
- Per job, it loads one weight tile from input SRAM, streams N activation vectors through the array, and drains the OFIFO to the psum SRAM.
- Optionally accumulates drained rows with stored psums through the SFU.
- Sits between the top-level testbench/host and the corelet; it is the only driver of the corelet's instruction and SRAM address ports.

Parameters:
- row, 8, MAC array rows; weight vectors per tile.
- col, 8, MAC array columns.
- addr_w, 11, SRAM address width.
- len_w, 8, width of the activation count.
- prop_cyc, 16, idle cycles after weight load before exec (default row+col).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- start  in  1  job request; sampled only when busy=0
- cfg_n_act  in  len_w  activation vectors in this job
- cfg_w_base  in  addr_w  input-SRAM address of weight row 0
- cfg_x_base  in  addr_w  input-SRAM address of activation 0
- cfg_p_base  in  addr_w  psum-SRAM base address
- cfg_mode  in  1  corelet mode bit
- cfg_acc  in  1  1 = accumulate through SFU
- ofifo_valid  in  1  OFIFO holds at least one full row
- inst  out  5  {l0_rd, l0_wr, mode, exec, weightload} to corelet
- xmem_cen  out  1  input-SRAM chip enable, active-low
- xmem_addr  out  addr_w  input-SRAM read address
- ofifo_rd  out  1  OFIFO pop
- sfu_en  out  1  corelet SFU select
- pmem_ren  out  1  psum-SRAM read strobe (acc mode only)
- pmem_raddr  out  addr_w  psum read address
- pmem_wen  out  1  psum-SRAM write strobe
- pmem_waddr  out  addr_w  psum write address
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (any state, including mid-job):
  - Next edge forces IDLE.
  - inst=0, xmem_cen=1, xmem_addr=0, ofifo_rd=0, sfu_en=0, pmem_ren=0, pmem_wen=0, both pmem addresses 0, busy=0, done=0.
  - All counters cleared.
- Config latch: all cfg_* are captured on the accepting start edge. Later changes are ignored until the next job. start while busy=1 is ignored.
- inst[2] equals the latched cfg_mode whenever busy=1; 0 otherwise.
- States:
  - IDLE: start=1 -> W_FILL; busy rises next cycle.
  - W_FILL: row cycles, xmem_cen=0, xmem_addr=w_base+i (i=0..row-1). l0_wr is xmem_cen inverted and delayed 1 cycle (1-cycle SRAM read latency). -> W_LOAD after the last l0_wr cycle.
  - W_LOAD: row cycles, l0_rd=1, weightload=1. -> W_PROP.
  - W_PROP: prop_cyc cycles, inst[4,3,1,0]=0. If n_act=0 -> DONE, else -> X_FILL.
  - X_FILL: n_act cycles, xmem_addr=x_base+j; l0_wr delayed as in W_FILL. -> EXEC after the last l0_wr.
  - EXEC: n_act cycles, l0_rd=1, exec=1. -> DRAIN.
  - DRAIN:
    - ofifo_rd = ofifo_valid AND popped<n_act (combinational).
    - Non-acc: pmem_wen pulses 1 cycle after each pop, waddr=p_base+k.
    - Acc: sfu_en=1 throughout DRAIN; pmem_ren with raddr=p_base+k in the pop cycle; pmem_wen with waddr=p_base+k 3 cycles after the pop (matches the SFU's 3-stage select delay).
    - -> DONE when popped=n_act and no write is outstanding.
  - DONE: done=1 for one cycle, busy=0 on the same edge. -> IDLE.
- Address arithmetic is modulo 2^addr_w; wrap is silent.
- Counters are len_w wide. n_act=2^len_w-1 must complete.
- ofifo_valid deasserting mid-drain stalls popping with no error. Outstanding pipelined writes still retire.
- A start that arrives in the same cycle as done is ignored; busy is still 1 in that cycle.

Optional Feature:
- Macro: CORELET_SEQ_PERF_EN.
- With the macro:
  - Adds output perf_cyc [31:0]: cycles from start acceptance to done.
  - Adds output perf_stall [15:0]: DRAIN cycles with ofifo_valid=0 and popped<n_act.
  - Both are cleared on job accept, hold after done, and reset to 0.
- Without the macro: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset mid-EXEC (n_act=4) -> next cycle inst=0, xmem_cen=1, busy=0; a new start is accepted normally.
- Non-acc job with w_base=0x000, x_base=0x040, p_base=0x100, n_act=4, ofifo_valid tied 1:
  - xmem_addr 0x000..0x007 then 0x040..0x043.
  - Exactly 8 weightload cycles and 4 exec cycles.
  - 4 writes to 0x100..0x103.
  - done occurs exactly once.
- Acc job, n_act=3, p_base=0x020 -> each pmem_ren addr k is followed exactly 3 cycles later by pmem_wen to the same addr; sfu_en=1 only during DRAIN.
- ofifo_valid toggled 1,0,0,1,1,0,1 during DRAIN with n_act=4 -> exactly 4 pops, no pop while valid=0, writes in order 0..3.
- n_act=0 -> after W_PROP go straight to DONE; zero exec cycles, zero pmem writes.
- start held high throughout a job and at done -> exactly one job runs; the second job starts only after busy=0 is observed.
